m4_video_capture: RTL
=====================

# m4_video_capture

Write-side front end of the frame buffer: samples the Model 4 monochrome dot stream with its horizontal and vertical syncs and writes one bit per pixel into the write port of the dual-port frame RAM. The VGA output stage reads that RAM at address (line × 800 + x). This block must therefore place captured source line N, dot D at address N×800 + D. It also reports frame completion and lock status for the front-panel logic.

## Interface

Parameters:
- `DOT_DIV`, default 2: clocks per source dot; range 2–15.
- `SAMPLE_PHASE`, default 1: clock within each dot period on which the video bit is taken; must be less than `DOT_DIV`.
- `H_OFFSET`, default 96: dots skipped after the hsync leading edge before capture starts.
- `V_OFFSET`, default 24: lines skipped after the vsync leading edge before capture starts.
- `ACTIVE_W`, default 640: dots captured per line.
- `ACTIVE_H`, default 240: lines captured per frame.
- `LINE_STRIDE`, default 800: RAM address step per line.
- `SYNC_POL`, default 0: sync active level; 0 means active-low.
- `VS_TIMEOUT`, default 2_000_000: clocks allowed without a vsync before lock is dropped.

Ports:
- `i_clk`, in, 1: capture clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_m4_video`, in, 1: source dot stream; asynchronous.
- `i_m4_hsync`, in, 1: source horizontal sync; asynchronous.
- `i_m4_vsync`, in, 1: source vertical sync; asynchronous.
- `o_waddr`, out, 18: RAM write address.
- `o_wdata`, out, 1: RAM write data.
- `o_we`, out, 1: RAM write enable; one write per asserted cycle.
- `o_frame_done`, out, 1: single-cycle pulse after the last pixel of a frame is written.
- `o_locked`, out, 1: source timing is valid.

## Operation

- All three inputs pass through a 2-FF synchronizer. Sync edges are detected on the synchronized value after `SYNC_POL` normalisation; only the leading (assertion) edge is used.
- State machine states:
  - **IDLE**: entered on reset. Waits for a vsync leading edge, then goes to VSKIP.
  - **VSKIP**: counts hsync edges. After `V_OFFSET` edges, goes to HSKIP with line = 0.
  - **HSKIP**: counts dots, where one dot is `DOT_DIV` clocks starting at the hsync edge. After `H_OFFSET` dots, goes to CAPTURE with dot = 0.
  - **CAPTURE**: on each `SAMPLE_PHASE` clock, writes the pixel and increments dot. When dot reaches `ACTIVE_W`, goes to LINEWAIT.
  - **LINEWAIT**: on an hsync edge, line is incremented. If line = `ACTIVE_H`, pulse `o_frame_done` and go to VSKIP-armed, which is IDLE. Otherwise go to HSKIP.
- Write address: line × `LINE_STRIDE` + dot, computed incrementally (base register plus `LINE_STRIDE` per line; no multiplier), truncated to 18 bits.
- An hsync edge during CAPTURE ends the line early: increment line and go to HSKIP. Dots not written keep their old RAM contents.
- A vsync edge in any state other than IDLE aborts the frame: go to VSKIP, line = 0, no `o_frame_done`.
- `o_locked` is set on `o_frame_done`. It is cleared on an aborted frame, or when `VS_TIMEOUT` clocks elapse without a vsync edge.
- Reset mid-frame returns the block to IDLE immediately. All counters are zeroed and `o_locked` is cleared.

## Timing

- Reset values: `o_waddr` = 0, `o_wdata` = 0, `o_we` = 0, `o_frame_done` = 0, `o_locked` = 0.
- Input to edge-detect latency is 3 clocks: 2 synchronizer stages plus 1 edge register. Dot phase counts from the edge-detect cycle.
- `o_we`, `o_waddr` and `o_wdata` are registered. They are valid together one clock after the sample clock, and `o_we` is high for exactly one clock per dot.
- Write spacing is exactly `DOT_DIV` clocks.
- `o_frame_done` is asserted one clock after the final write's `o_we` cycle.

## Structure

- Shared package `m4vga_pkg`: the 18-bit RAM address typedef (replacing the local TRUNC typedef), the `LINE_STRIDE` constant 800, and the default active geometry of 640×240. Both the capture stage and the VGA output stage import it.
- Sub-module `sync_edge_det`: 2-FF synchronizer, polarity normalisation and leading-edge pulse. Instantiated three times; the video-input instance uses only the synchronized level.

## Test plan

Unless stated, tests use `DOT_DIV` = 2, `H_OFFSET` = 4, `V_OFFSET` = 2, `ACTIVE_W` = 8, `ACTIVE_H` = 3 and `LINE_STRIDE` = 800.

- **Full frame, alternating pixels.** Drive a 10101010 video pattern for a full frame. Expect 24 writes at addresses 0–7, 800–807 and 1600–1607, with data 1,0,1,0…. Expect `o_frame_done` to pulse once and `o_locked` to be 1.
- **Short line.** Send an hsync edge after dot 5 of line 1. Expect line 1 to write only addresses 800–804, line 2 to start at 1600, and `o_frame_done` still to pulse.
- **Vsync mid-frame.** Send a vsync edge during line 1. Expect no `o_frame_done`, `o_locked` to fall, and the next writes to start at address 0 after 2 hsync edges.
- **Lost source.** Stop vsync with `VS_TIMEOUT` = 1000. Expect `o_locked` to fall at clock 1000 after the last vsync edge.
- **Async reset during CAPTURE.** Assert `i_rst_n` low while capturing. Expect all outputs to read 0 in the same cycle, and capture to resume only after the next vsync edge.
- **Polarity and phase.** Run with `SYNC_POL` = 1 and `SAMPLE_PHASE` = 0. Expect the same addresses as the first test, with each sample taken on the first clock of each dot.

Source files
------------

// File: rtl/m4vga_pkg.sv
// Shared frame-buffer definitions for the Model 4 capture and VGA output stages.
package m4vga_pkg;

  localparam int ADDR_W = 18;
  typedef logic [ADDR_W-1:0] ram_addr_t;

  localparam int M4_LINE_STRIDE = 800;
  localparam int M4_ACTIVE_W    = 640;
  localparam int M4_ACTIVE_H    = 240;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VSKIP    = 3'd1,
    ST_HSKIP    = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_LINEWAIT = 3'd4
  } cap_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with polarity normalisation; level and leading-edge
// pulse share the same three-clock latency so video stays aligned with the syncs.
module sync_edge_det #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic lead_edge
);

  logic [1:0] sync_r;
  logic       lvl_s;
  logic       prev_r;
  logic       edge_r;

  // Stages reset to the inactive level so release from reset never fakes an edge.
  assign lvl_s = POL ? sync_r[1] : ~sync_r[1];

  // Synchronizer, delayed level and leading-edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {2{~POL}};
      prev_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], din};
      prev_r <= lvl_s;
      edge_r <= lvl_s & ~prev_r;
    end
  end

  assign level     = prev_r;
  assign lead_edge = edge_r;

endmodule

// File: rtl/m4_video_capture.sv
// Captures the Model 4 dot stream into the frame RAM write port, placing source
// line N, dot D at N*LINE_STRIDE + D, and reports frame completion and lock.
module m4_video_capture
  import m4vga_pkg::*;
#(
  parameter int DOT_DIV      = 2,
  parameter int SAMPLE_PHASE = 1,
  parameter int H_OFFSET     = 96,
  parameter int V_OFFSET     = 24,
  parameter int ACTIVE_W     = M4_ACTIVE_W,
  parameter int ACTIVE_H     = M4_ACTIVE_H,
  parameter int LINE_STRIDE  = M4_LINE_STRIDE,
  parameter bit SYNC_POL     = 1'b0,
  parameter int VS_TIMEOUT   = 2_000_000
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_m4_video,
  input  logic      i_m4_hsync,
  input  logic      i_m4_vsync,
  output ram_addr_t o_waddr,
  output logic      o_wdata,
  output logic      o_we,
  output logic      o_frame_done,
  output logic      o_locked
);

  localparam int TO_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
  localparam logic [3:0]      PH_LAST   = 4'(DOT_DIV - 1);
  localparam logic [3:0]      PH_SAMPLE = 4'(SAMPLE_PHASE);
  localparam logic [15:0]     V_LAST    = 16'(V_OFFSET - 1);
  localparam logic [15:0]     H_LAST    = 16'(H_OFFSET - 1);
  localparam logic [15:0]     W_LAST    = 16'(ACTIVE_W - 1);
  localparam logic [15:0]     LINE_LAST = 16'(ACTIVE_H - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(VS_TIMEOUT - 1);
  localparam ram_addr_t       STRIDE    = ram_addr_t'(LINE_STRIDE);

  logic       vid_s, hs_edge_s, vs_edge_s;
  logic       vid_edge_unused, hs_level_unused, vs_level_unused;
  cap_state_t state_r;
  logic [3:0] phase_r;
  logic [15:0] cnt_r, line_r;
  ram_addr_t  base_r, waddr_r;
  logic       wdata_r, we_r, frame_done_r, locked_r, done_pend_r;
  logic [TO_W-1:0] to_cnt_r;

  sync_edge_det #(.POL(1'b1)) u_vid (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_m4_video),
    .level(vid_s), .lead_edge(vid_edge_unused)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_hs (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_m4_hsync),
    .level(hs_level_unused), .lead_edge(hs_edge_s)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vs (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_m4_vsync),
    .level(vs_level_unused), .lead_edge(vs_edge_s)
  );

  // Capture sequencer: frame/line tracking, pixel writes, frame-done and lock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      phase_r      <= 4'd0;
      cnt_r        <= 16'd0;
      line_r       <= 16'd0;
      base_r       <= '0;
      waddr_r      <= '0;
      wdata_r      <= 1'b0;
      we_r         <= 1'b0;
      frame_done_r <= 1'b0;
      done_pend_r  <= 1'b0;
      locked_r     <= 1'b0;
      to_cnt_r     <= '0;
    end else begin
      we_r         <= 1'b0;
      done_pend_r  <= 1'b0;
      frame_done_r <= done_pend_r;
      phase_r      <= (phase_r == PH_LAST) ? 4'd0 : phase_r + 4'd1;
      if (done_pend_r) begin
        locked_r <= 1'b1;
      end
      // Counter value k means k clocks since the clock that saw the vsync edge.
      if (vs_edge_s) begin
        to_cnt_r <= TO_W'(1);
      end else if (to_cnt_r != TO_LAST) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end

      if (vs_edge_s) begin
        state_r <= ST_VSKIP;
        cnt_r   <= 16'd0;
        line_r  <= 16'd0;
        base_r  <= '0;
        if (state_r != ST_IDLE) begin
          locked_r <= 1'b0;
        end
      end else if (hs_edge_s && (state_r == ST_CAPTURE || state_r == ST_LINEWAIT)) begin
        // Line may end early; unwritten dots keep their old RAM contents.
        if (line_r == LINE_LAST) begin
          state_r     <= ST_IDLE;
          done_pend_r <= 1'b1;
        end else begin
          state_r <= ST_HSKIP;
          line_r  <= line_r + 16'd1;
          base_r  <= base_r + STRIDE;
          cnt_r   <= 16'd0;
          phase_r <= 4'd1;
        end
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_VSKIP: begin
            if (hs_edge_s) begin
              if (cnt_r == V_LAST) begin
                state_r <= ST_HSKIP;
                cnt_r   <= 16'd0;
                phase_r <= 4'd1;
              end else begin
                cnt_r <= cnt_r + 16'd1;
              end
            end
          end
          ST_HSKIP: begin
            if (phase_r == PH_LAST) begin
              if (cnt_r == H_LAST) begin
                state_r <= ST_CAPTURE;
                cnt_r   <= 16'd0;
              end else begin
                cnt_r <= cnt_r + 16'd1;
              end
            end
          end
          ST_CAPTURE: begin
            if (phase_r == PH_SAMPLE) begin
              we_r    <= 1'b1;
              wdata_r <= vid_s;
              waddr_r <= base_r + ram_addr_t'(cnt_r);
              if (cnt_r == W_LAST) begin
                if (line_r == LINE_LAST) begin
                  state_r     <= ST_IDLE;
                  done_pend_r <= 1'b1;
                end else begin
                  state_r <= ST_LINEWAIT;
                end
              end else begin
                cnt_r <= cnt_r + 16'd1;
              end
            end
          end
          ST_LINEWAIT: state_r <= ST_LINEWAIT;
          default:     state_r <= ST_IDLE;
        endcase
      end

      if (to_cnt_r == TO_LAST) begin
        locked_r <= 1'b0;
      end
    end
  end

  assign o_waddr      = waddr_r;
  assign o_wdata      = wdata_r;
  assign o_we         = we_r;
  assign o_frame_done = frame_done_r;
  assign o_locked     = locked_r;

endmodule
